// File: rtl/keypad_scanner_fifo_pkg.sv
// Shared constants, FSM states and key legend for the keypad scanner.
package keypad_pkg;

    localparam int unsigned KEYCODE_W = 6;
    localparam int unsigned BUS_W     = 16;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERFLOW  = 2;
    localparam int unsigned STAT_SCANNING  = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned DATA_VALID     = 15;

    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;
    localparam int unsigned CTRL_FLUSH   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_SCAN,
        S_PUSH,
        S_RELEASE
    } scan_state_e;

    // Printed legend of the standard 4x4 pad, row-major.
    function automatic logic [3:0] keycode_to_hex(input logic [KEYCODE_W-1:0] code);
        case (code)
            6'd0:    return 4'h1;
            6'd1:    return 4'h2;
            6'd2:    return 4'h3;
            6'd3:    return 4'hA;
            6'd4:    return 4'h4;
            6'd5:    return 4'h5;
            6'd6:    return 4'h6;
            6'd7:    return 4'hB;
            6'd8:    return 4'h7;
            6'd9:    return 4'h8;
            6'd10:   return 4'h9;
            6'd11:   return 4'hC;
            6'd12:   return 4'hE;
            6'd13:   return 4'h0;
            6'd14:   return 4'hF;
            6'd15:   return 4'hD;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_fifo_if.sv
// CPU peripheral bus between the host and the keypad controller.
interface keypad_scanner_fifo_if;
    logic        keyboard_ctrl;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  address;
    logic [15:0] write_data;
    logic [15:0] read_data_output;
    logic        irq;

    modport master (
        output keyboard_ctrl, read_enable, write_enable, address, write_data,
        input  read_data_output, irq
    );

    modport slave (
        input  keyboard_ctrl, read_enable, write_enable, address, write_data,
        output read_data_output, irq
    );
endinterface

// File: rtl/keypad_scanner_fifo_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds only with a same-cycle pop.
module keypad_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head_c,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full_c,
    output logic                       o_empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full_c  = (r_count == FULL_CNT);
    assign o_empty_c = (r_count == '0);
endmodule

// File: rtl/keypad_scanner_fifo.sv
// ROWSxCOLS keypad scanner with debounce, key-code FIFO and CPU register file.
module keypad_scanner_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 200,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    keypad_scanner_fifo_if.slave bus,
    input  logic [COLS-1:0]      column,
    output logic [ROWS-1:0]      row
);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned MAXC  = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAXC + 1);
    localparam int unsigned QW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0]    LAST_ROW    = RW'(ROWS - 1);

    scan_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [RW-1:0]        r_row_idx;
    logic [ROWS-1:0]      r_row;
    logic [KEYCODE_W-1:0] r_code;
    logic [COLS-1:0]      r_col_m;
    logic [COLS-1:0]      r_col_s;
    logic                 r_enable;
    logic                 r_irq_en;
    logic                 r_overflow;
    logic                 r_irq;
    logic [BUS_W-1:0]     r_rdata;

    logic                 w_any_low;
    logic [CW-1:0]        w_col_idx;
    logic [KEYCODE_W-1:0] w_code;
    logic                 w_rd;
    logic                 w_wr_ctrl;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_scanning;
    logic [KEYCODE_W-1:0] w_head;
    logic [QW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [BUS_W-1:0]     w_rdata;
    logic                 w_unused_wdata;

    // Columns are asynchronous to clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col_m <= '1;
            r_col_s <= '1;
        end else begin
            r_col_m <= column;
            r_col_s <= r_col_m;
        end
    end

    assign w_any_low = ~&r_col_s;

    // Lowest-index low column wins when several keys share a row.
    always_comb begin
        w_col_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!r_col_s[c]) w_col_idx = CW'(c);
        end
        w_code = KEYCODE_W'(32'(r_row_idx) * COLS + 32'(w_col_idx));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_row_idx <= '0;
            r_row     <= '0;
            r_code    <= '0;
        end else if (!r_enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_row <= '0;
                    if (w_any_low) r_state <= S_DEBOUNCE;
                end
                S_DEBOUNCE: begin
                    if (!w_any_low) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state   <= S_SCAN;
                        r_cnt     <= '0;
                        r_row_idx <= '0;
                        r_row     <= ~ROWS'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SCAN: begin
                    if (r_cnt != SETTLE_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (w_any_low) begin
                            r_code  <= w_code;
                            r_row   <= '0;
                            r_state <= S_PUSH;
                        end else if (r_row_idx == LAST_ROW) begin
                            r_row   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_row_idx <= r_row_idx + RW'(1);
                            r_row     <= ~(ROWS'(1) << (r_row_idx + RW'(1)));
                        end
                    end
                end
                S_PUSH: begin
                    r_cnt   <= '0;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_row <= '0;
                    if (w_any_low) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign row        = r_row;
    assign w_scanning = (r_state == S_DEBOUNCE) || (r_state == S_SCAN) || (r_state == S_PUSH);
    assign w_rd       = bus.keyboard_ctrl && bus.read_enable;
    assign w_wr_ctrl  = bus.keyboard_ctrl && bus.write_enable && (bus.address == ADDR_CTRL);
    assign w_push     = (r_state == S_PUSH);
    assign w_pop      = w_rd && (bus.address == ADDR_DATA) && !w_empty;
    assign w_flush    = w_wr_ctrl && bus.write_data[CTRL_FLUSH];
    assign w_unused_wdata = ^bus.write_data[BUS_W-1:CTRL_FLUSH+1];

    keypad_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KEYCODE_W)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (w_flush),
        .i_data   (r_code),
        .o_head_c (w_head),
        .o_count  (w_count),
        .o_full_c (w_full),
        .o_empty_c(w_empty)
    );

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA: begin
                if (!w_empty) begin
                    w_rdata[DATA_VALID]      = 1'b1;
                    w_rdata[KEYCODE_W-1:0]   = w_head;
                end
            end
            ADDR_STATUS: begin
                w_rdata[BUS_W-1:STAT_COUNT_LSB] = 8'(w_count);
                w_rdata[STAT_SCANNING]          = w_scanning;
                w_rdata[STAT_OVERFLOW]          = r_overflow;
                w_rdata[STAT_FULL]              = w_full;
                w_rdata[STAT_NOT_EMPTY]         = !w_empty;
            end
            ADDR_CTRL: begin
                w_rdata[CTRL_ENABLE] = r_enable;
                w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            default: w_rdata = '0;
        endcase
    end

    // A flush swallows a coincident push without flagging overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata    <= '0;
            r_irq      <= 1'b0;
            r_enable   <= 1'b1;
            r_irq_en   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rdata;
            if (w_wr_ctrl) begin
                r_enable <= bus.write_data[CTRL_ENABLE];
                r_irq_en <= bus.write_data[CTRL_IRQ_EN];
            end
            if (w_push && w_full && !w_pop && !w_flush) r_overflow <= 1'b1;
            else if (w_wr_ctrl && bus.write_data[CTRL_CLR_OVF]) r_overflow <= 1'b0;
            r_irq <= r_irq_en && !w_empty;
        end
    end

    assign bus.read_data_output = r_rdata;
    assign bus.irq              = r_irq;
endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Directed bench for keypad_scanner_fifo with a 4x4 key-matrix model.
module tb_keypad_scanner_fifo;
    import keypad_pkg::*;

    logic        clock;
    logic        reset;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [15:0] keys;
    logic [3:0]  force_low;
    logic [15:0] d;
    int          n_checks;
    int          n_errors;

    keypad_scanner_fifo_if bus();

    keypad_scanner_fifo #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(10), .SETTLE_CYCLES(4), .FIFO_DEPTH(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .column(column),
        .row   (row)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pressed key pulls its column low while its row is driven low.
    always_comb begin
        column = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) column[c] = 1'b0;
        column = column & ~force_low;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] q);
        @(negedge clock);
        bus.keyboard_ctrl = 1'b1;
        bus.read_enable   = 1'b1;
        bus.address       = a;
        @(negedge clock);
        bus.keyboard_ctrl = 1'b0;
        bus.read_enable   = 1'b0;
        q = bus.read_data_output;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] v);
        @(negedge clock);
        bus.keyboard_ctrl = 1'b1;
        bus.write_enable  = 1'b1;
        bus.address       = a;
        bus.write_data    = v;
        @(negedge clock);
        bus.keyboard_ctrl = 1'b0;
        bus.write_enable  = 1'b0;
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        repeat (100) @(negedge clock);
        keys[k] = 1'b0;
        repeat (30) @(negedge clock);
    endtask

    task automatic wait_row(input logic [3:0] v, input string tag);
        int n;
        n = 0;
        while (row !== v && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, 16'(row === v), 16'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        keys = '0;
        force_low = '0;
        bus.keyboard_ctrl = 1'b0;
        bus.read_enable   = 1'b0;
        bus.write_enable  = 1'b0;
        bus.address       = '0;
        bus.write_data    = '0;
        repeat (3) @(negedge clock);
        check("rst_row", 16'(row), 16'h0000);
        check("rst_rdata", bus.read_data_output, 16'h0000);
        check("rst_irq", 16'(bus.irq), 16'h0000);
        reset = 1'b0;
        bus_read(ADDR_STATUS, d); check("rst_status", d, 16'h0000);
        bus_read(ADDR_CTRL, d);   check("rst_ctrl", d, 16'h0001);

        // Single press of key 6 (row 1, column 2).
        press(6);
        bus_read(ADDR_STATUS, d); check("single_status", d, 16'h0101);
        bus_read(ADDR_DATA, d);   check("single_data", d, 16'h8006);
        check("legend_6", 16'(keycode_to_hex(d[5:0])), 16'h0006);
        bus_read(ADDR_DATA, d);   check("single_empty", d, 16'h0000);
        bus_read(4'd6, d);        check("other_addr", d, 16'h0000);

        // Bounce shorter than the debounce window.
        force_low = 4'b0001;
        repeat (3) @(negedge clock);
        bus_read(ADDR_STATUS, d); check("bounce_scanning", d, 16'h0008);
        force_low = 4'b0000;
        repeat (8) @(negedge clock);
        bus_read(ADDR_STATUS, d); check("bounce_idle", d, 16'h0000);

        // Two keys in row 3: column 1 wins.
        keys[13] = 1'b1; keys[15] = 1'b1;
        repeat (100) @(negedge clock);
        keys = '0;
        repeat (30) @(negedge clock);
        bus_read(ADDR_DATA, d);   check("two_cols_data", d, 16'h800D);
        bus_read(ADDR_DATA, d);   check("two_cols_once", d, 16'h0000);

        // Nine presses into an 8-deep FIFO.
        for (int k = 0; k < 9; k++) press(k);
        bus_read(ADDR_STATUS, d); check("ovf_status", d, 16'h0807);
        bus_read(ADDR_DATA, d);   check("ovf_first", d, 16'h8000);
        bus_write(ADDR_CTRL, 16'h0005);
        bus_read(ADDR_STATUS, d); check("ovf_cleared", d, 16'h0701);
        press(9);
        bus_read(ADDR_STATUS, d); check("refill_status", d, 16'h0803);
        bus_write(ADDR_CTRL, 16'h0009);
        bus_read(ADDR_STATUS, d); check("flush_status", d, 16'h0000);
        bus_read(ADDR_CTRL, d);   check("flush_ctrl", d, 16'h0001);

        // Interrupt timing relative to the push.
        bus_write(ADDR_CTRL, 16'h0003);
        keys[6] = 1'b1;
        wait_row(4'b1101, "irq_row1_timeout");
        for (int n = 0; n < 10 && row === 4'b1101; n++) @(negedge clock);
        check("irq_hit_row", 16'(row), 16'h0000);
        check("irq_before_push", 16'(bus.irq), 16'h0000);
        @(negedge clock);
        check("irq_at_push", 16'(bus.irq), 16'h0000);
        @(negedge clock);
        check("irq_after_push", 16'(bus.irq), 16'h0001);
        keys = '0;
        repeat (40) @(negedge clock);
        bus_read(ADDR_DATA, d);   check("irq_data", d, 16'h8006);
        check("irq_hold", 16'(bus.irq), 16'h0001);
        @(negedge clock);
        check("irq_drop", 16'(bus.irq), 16'h0000);

        // Reset in the middle of a scan.
        press(0);
        check("pre_rst_irq", 16'(bus.irq), 16'h0001);
        keys[4] = 1'b1;
        wait_row(4'b1101, "scan_row1_timeout");
        reset = 1'b1;
        #1;
        check("mid_rst_row", 16'(row), 16'h0000);
        check("mid_rst_rdata", bus.read_data_output, 16'h0000);
        check("mid_rst_irq", 16'(bus.irq), 16'h0000);
        keys = '0;
        @(negedge clock);
        reset = 1'b0;
        bus_read(ADDR_STATUS, d); check("post_rst_status", d, 16'h0000);
        bus_read(ADDR_CTRL, d);   check("post_rst_ctrl", d, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
